// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU datapath: select codes, widths,
// sequencer state encoding and the operand/result bundles.
package alu_pkg;

    localparam int DATA_W = 8;
    localparam int SEL_W  = 4;

    // Number of legal select codes; codes at or above this are illegal.
    localparam int DEF_NUM_OPS = 8;

    localparam logic [SEL_W-1:0] OP_ADD = 4'h0;
    localparam logic [SEL_W-1:0] OP_SUB = 4'h1;
    localparam logic [SEL_W-1:0] OP_AND = 4'h2;
    localparam logic [SEL_W-1:0] OP_OR  = 4'h3;
    localparam logic [SEL_W-1:0] OP_XOR = 4'h4;
    localparam logic [SEL_W-1:0] OP_NOT = 4'h5;
    localparam logic [SEL_W-1:0] OP_SHL = 4'h6;
    localparam logic [SEL_W-1:0] OP_SHR = 4'h7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXEC   = 2'd1,
        WAIT   = 2'd2,
        RESULT = 2'd3
    } seq_state_t;

    // Operands held for the ALU between accepts
    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [SEL_W-1:0]  sel;
    } alu_req_t;

    // Captured result presented downstream
    typedef struct packed {
        logic [DATA_W-1:0] y;
        logic              zero;
        logic              neg;
        logic              err;
    } alu_rsp_t;

    // True when a select code names an implemented operation
    function automatic logic sel_is_legal(input logic [SEL_W-1:0] sel, input int num_ops);
        return int'(sel) < num_ops;
    endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Zero / negative flag derivation for an 8-bit two's-complement value.
module alu_flag_gen
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] value,
    output logic              zero,
    output logic              neg
);

    // Pure combinational decode; shared with the ALU result path
    always_comb begin
        zero = (value == '0);
        neg  = value[DATA_W-1];
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU operation at a time: accept operands, strobe alu_do,
// wait a fixed ALU latency, capture Y with flags, hand the result off.
// Legal ops take LATENCY+2 cycles from accept to out_valid; illegal
// selects skip the ALU and report an error result one cycle after accept.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int LATENCY = 1,            // 1..7
    parameter int NUM_OPS = DEF_NUM_OPS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [SEL_W-1:0]  in_sel,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [SEL_W-1:0]  alu_sel,
    output logic              alu_do,
    input  logic [DATA_W-1:0] alu_y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_y,
    output logic              out_zero,
    output logic              out_neg,
    output logic              out_err,
    output logic [7:0]        op_count
);

    localparam int               CNT_W     = 3;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(LATENCY - 1);

    seq_state_t       state;
    logic [CNT_W-1:0] wait_cnt;
    alu_req_t         req_q;
    alu_rsp_t         rsp_q;
    logic             accept;
    logic             y_zero;
    logic             y_neg;

    alu_flag_gen u_flags (
        .value (alu_y),
        .zero  (y_zero),
        .neg   (y_neg)
    );

    // Ready is dropped during reset so nothing is taken on a reset edge
    assign in_ready = (state == IDLE) && !reset;
    assign accept   = in_valid && in_ready;

    assign alu_a    = req_q.a;
    assign alu_b    = req_q.b;
    assign alu_sel  = req_q.sel;
    assign out_y    = rsp_q.y;
    assign out_zero = rsp_q.zero;
    assign out_neg  = rsp_q.neg;
    assign out_err  = rsp_q.err;

    // Sequencer FSM with wait counter, result capture and op counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            req_q     <= '0;
            rsp_q     <= '0;
            alu_do    <= 1'b0;
            out_valid <= 1'b0;
            op_count  <= '0;
        end else begin
            // Strobe is only ever raised for the single EXEC cycle
            alu_do <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        req_q.a   <= in_a;
                        req_q.b   <= in_b;
                        req_q.sel <= in_sel;
                        if (sel_is_legal(in_sel, NUM_OPS)) begin
                            alu_do <= 1'b1;
                            state  <= EXEC;
                        end else begin
                            // Bypass the ALU entirely: zero result flagged as error
                            rsp_q.y    <= '0;
                            rsp_q.zero <= 1'b1;
                            rsp_q.neg  <= 1'b0;
                            rsp_q.err  <= 1'b1;
                            out_valid  <= 1'b1;
                            state      <= RESULT;
                        end
                    end
                end
                EXEC: begin
                    wait_cnt <= WAIT_LOAD;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end else begin
                        rsp_q.y    <= alu_y;
                        rsp_q.zero <= y_zero;
                        rsp_q.neg  <= y_neg;
                        rsp_q.err  <= 1'b0;
                        out_valid  <= 1'b1;
                        state      <= RESULT;
                    end
                end
                RESULT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        op_count  <= op_count + 8'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed scenarios plus a
// randomized run scored against a behavioural model of the op contract.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // LATENCY=1 instance
    logic       in_valid, in_ready, alu_do, out_valid, out_ready;
    logic       out_zero, out_neg, out_err;
    logic [7:0] in_a, in_b, alu_a, alu_b, alu_y, out_y, op_count;
    logic [3:0] in_sel, alu_sel;

    // LATENCY=4 instance
    logic       in_valid4, in_ready4, alu_do4, out_valid4, out_ready4;
    logic       out_zero4, out_neg4, out_err4;
    logic [7:0] in_a4, in_b4, alu_a4, alu_b4, alu_y4, out_y4, op_count4;
    logic [3:0] in_sel4, alu_sel4;

    int n_checks = 0;
    int n_fail   = 0;

    alu_op_sequencer #(.LATENCY(1), .NUM_OPS(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_do(alu_do),
        .alu_y(alu_y),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_zero(out_zero), .out_neg(out_neg), .out_err(out_err),
        .op_count(op_count)
    );

    alu_op_sequencer #(.LATENCY(4), .NUM_OPS(8)) dut4 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .in_a(in_a4), .in_b(in_b4), .in_sel(in_sel4),
        .alu_a(alu_a4), .alu_b(alu_b4), .alu_sel(alu_sel4), .alu_do(alu_do4),
        .alu_y(alu_y4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .out_y(out_y4), .out_zero(out_zero4), .out_neg(out_neg4), .out_err(out_err4),
        .op_count(op_count4)
    );

    // Arithmetic meaning of each select code
    function automatic logic [7:0] ref_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
        case (sel)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return a ^ b;
            4'h5: return ~a;
            4'h6: return a << 1;
            4'h7: return a >> 1;
            default: return 8'h00;
        endcase
    endfunction

    // ALU models: Y registered LATENCY cycles after the do strobe
    initial alu_y = 8'h5A;
    always @(posedge clk) if (alu_do) alu_y <= ref_op(alu_a, alu_b, alu_sel);

    logic [7:0] pend4;
    int         cnt4 = 0;
    initial alu_y4 = 8'hA5;
    always @(posedge clk) begin
        if (alu_do4) begin
            pend4 <= ref_op(alu_a4, alu_b4, alu_sel4);
            cnt4  <= 3;
        end else if (cnt4 > 0) begin
            cnt4 <= cnt4 - 1;
            if (cnt4 == 1) alu_y4 <= pend4;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one op; returns after the accepting edge (ok=0 if never ready)
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel, output bit ok);
        int n = 0;
        in_a = a; in_b = b; in_sel = sel; in_valid = 1'b1;
        while (!in_ready && n < 10) begin tick(); n++; end
        ok = in_ready;
        tick();
        in_valid = 1'b0;
    endtask

    // Cycles from accept until out_valid seen (1 = cycle after accept), counting alu_do
    task automatic wait_result(output int lat, output int dos, output bit ok);
        lat = 1; dos = 0;
        while (1) begin
            if (alu_do) dos++;
            if (out_valid || lat >= 30) break;
            tick();
            lat++;
        end
        ok = out_valid;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0; in_sel = '0;
        in_valid4 = 1'b0; out_ready4 = 1'b0; in_a4 = '0; in_b4 = '0; in_sel4 = '0;
        tick(); tick(); tick();
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        n_checks++; if ({out_valid, alu_do, out_err, out_zero, out_neg} !== 5'b0) begin n_fail++; $display("FAIL reset_flags got=%b exp=00000", {out_valid, alu_do, out_err, out_zero, out_neg}); end
        n_checks++; if ({alu_a, alu_b, alu_sel, out_y, op_count} !== 36'h0) begin n_fail++; $display("FAIL reset_regs got=%h exp=0", {alu_a, alu_b, alu_sel, out_y, op_count}); end
        n_checks++; if ({in_ready4, out_valid4, op_count4} !== 10'h0) begin n_fail++; $display("FAIL reset_dut4 got=%h exp=0", {in_ready4, out_valid4, op_count4}); end
        reset = 1'b0;
        tick();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_sub_stall();
        bit ok; int lat, dos; logic [7:0] y0;
        issue(8'h05, 8'h03, OP_SUB, ok);
        wait_result(lat, dos, ok);
        n_checks++; if (!ok || lat != 3) begin n_fail++; $display("FAIL sub_latency got=%0d exp=3", lat); end
        y0 = out_y;
        for (int i = 0; i < 4; i++) begin
            if (alu_do) dos++;
            n_checks++; if (out_valid !== 1'b1 || out_y !== y0) begin n_fail++; $display("FAIL sub_stall_hold cyc=%0d valid=%b y=%h exp valid=1 y=%h", i, out_valid, out_y, y0); end
            tick();
        end
        n_checks++; if (dos != 1) begin n_fail++; $display("FAIL sub_do_pulses got=%0d exp=1", dos); end
        n_checks++; if ({out_y, out_zero, out_neg, out_err} !== {8'h02, 3'b000}) begin n_fail++; $display("FAIL sub_result got=%h/%b%b%b exp=02/000", out_y, out_zero, out_neg, out_err); end
        n_checks++; if (op_count !== 8'd0) begin n_fail++; $display("FAIL sub_count_before got=%0d exp=0", op_count); end
        handshake();
        n_checks++; if (op_count !== 8'd1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL sub_count_after got=%0d valid=%b exp=1 valid=0", op_count, out_valid); end
    endtask

    task automatic test_flags();
        bit ok; int lat, dos;
        issue(8'h10, 8'h10, OP_SUB, ok);
        wait_result(lat, dos, ok);
        n_checks++; if ({out_y, out_zero, out_neg, out_err} !== {8'h00, 3'b100}) begin n_fail++; $display("FAIL sub_zero got=%h/%b%b%b exp=00/100", out_y, out_zero, out_neg, out_err); end
        handshake();
        issue(8'h03, 8'h05, OP_SUB, ok);
        wait_result(lat, dos, ok);
        n_checks++; if ({out_y, out_zero, out_neg, out_err} !== {8'hFE, 3'b010}) begin n_fail++; $display("FAIL sub_neg got=%h/%b%b%b exp=FE/010", out_y, out_zero, out_neg, out_err); end
        handshake();
        n_checks++; if (op_count !== 8'd3) begin n_fail++; $display("FAIL flags_count got=%0d exp=3", op_count); end
    endtask

    task automatic test_illegal();
        bit ok; int lat, dos;
        logic [3:0] sels [3];
        sels[0] = 4'hF; sels[1] = 4'h8; sels[2] = OP_SHR;
        for (int k = 0; k < 3; k++) begin
            logic [7:0] cnt0;
            bit         bad;
            cnt0 = op_count;
            bad  = (sels[k] >= 4'd8);
            issue(8'h9C, 8'h21, sels[k], ok);
            wait_result(lat, dos, ok);
            n_checks++; if (!ok || lat != (bad ? 1 : 3) || dos != (bad ? 0 : 1)) begin n_fail++; $display("FAIL illegal_timing sel=%h lat=%0d dos=%0d exp lat=%0d dos=%0d", sels[k], lat, dos, bad ? 1 : 3, bad ? 0 : 1); end
            if (bad) begin
                n_checks++; if ({out_y, out_zero, out_neg, out_err} !== {8'h00, 3'b101}) begin n_fail++; $display("FAIL illegal_result sel=%h got=%h/%b%b%b exp=00/101", sels[k], out_y, out_zero, out_neg, out_err); end
            end else begin
                n_checks++; if ({out_y, out_err} !== {8'h4E, 1'b0}) begin n_fail++; $display("FAIL legal_boundary got=%h err=%b exp=4E err=0", out_y, out_err); end
            end
            handshake();
            n_checks++; if (op_count !== cnt0 + 8'd1) begin n_fail++; $display("FAIL illegal_count got=%0d exp=%0d", op_count, cnt0 + 8'd1); end
        end
    endtask

    task automatic test_back_to_back();
        int acc_cyc[$];
        logic [7:0] res[$];
        int i = 0, vcyc = 0;
        bit acc, hs; logic [7:0] y;
        pulse_reset();
        out_ready = 1'b1;
        in_a = 8'd0; in_b = 8'd1; in_sel = OP_ADD; in_valid = 1'b1;
        for (int c = 0; c < 200 && res.size() < 10; c++) begin
            acc = in_valid && in_ready;
            hs  = out_valid && out_ready;
            y   = out_y;
            if (out_valid) vcyc++;
            tick();
            if (acc) begin
                acc_cyc.push_back(c);
                i++;
                in_a = 8'(i);
                if (i == 10) in_valid = 1'b0;
            end
            if (hs) res.push_back(y);
        end
        out_ready = 1'b0;
        n_checks++; if (res.size() != 10) begin n_fail++; $display("FAIL b2b_results got=%0d exp=10", res.size()); end
        for (int k = 0; k < res.size(); k++) begin
            n_checks++; if (res[k] !== 8'(k + 1)) begin n_fail++; $display("FAIL b2b_order idx=%0d got=%h exp=%h", k, res[k], 8'(k + 1)); end
        end
        for (int k = 1; k < acc_cyc.size(); k++) begin
            n_checks++; if (acc_cyc[k] - acc_cyc[k-1] != 4) begin n_fail++; $display("FAIL b2b_gap idx=%0d got=%0d exp=4", k, acc_cyc[k] - acc_cyc[k-1]); end
        end
        n_checks++; if (vcyc != 10) begin n_fail++; $display("FAIL b2b_valid_cycles got=%0d exp=10", vcyc); end
        n_checks++; if (op_count !== 8'd10) begin n_fail++; $display("FAIL b2b_count got=%0d exp=10", op_count); end
    endtask

    // 246 random ops on top of the 10 above: counter must wrap to 0
    task automatic test_random_wrap();
        bit ok; int lat, dos, done = 10;
        logic [7:0] a, b, ey; logic [3:0] s; bit bad;
        for (int n = 0; n < 246; n++) begin
            a = 8'($urandom); b = 8'($urandom);
            s = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
            bad = (s >= 4'd8);
            ey  = bad ? 8'h00 : ref_op(a, b, s);
            issue(a, b, s, ok);
            wait_result(lat, dos, ok);
            for (int st = $urandom_range(0, 2); st > 0; st--) tick();
            n_checks++;
            if (!ok || lat != (bad ? 1 : 3) || out_y !== ey || out_err !== bad ||
                out_zero !== (ey == 8'h00) || out_neg !== ey[7]) begin
                n_fail++;
                $display("FAIL rand_op n=%0d a=%h b=%h sel=%h got lat=%0d y=%h z=%b n=%b e=%b exp lat=%0d y=%h z=%b n=%b e=%b",
                         n, a, b, s, lat, out_y, out_zero, out_neg, out_err, bad ? 1 : 3, ey, ey == 8'h00, ey[7], bad);
            end
            handshake();
            done++;
            n_checks++; if (op_count !== 8'(done % 256)) begin n_fail++; $display("FAIL rand_count n=%0d got=%0d exp=%0d", n, op_count, done % 256); end
        end
        n_checks++; if (op_count !== 8'h00) begin n_fail++; $display("FAIL wrap_count got=%h exp=00", op_count); end
    endtask

    task automatic test_reset_mid_op();
        bit ok; int lat, dos, vseen = 0;
        issue(8'h01, 8'h01, OP_ADD, ok);
        wait_result(lat, dos, ok);
        handshake();
        // Reset during WAIT
        issue(8'h22, 8'h11, OP_ADD, ok);
        tick();
        reset = 1'b1;
        tick();
        n_checks++; if ({out_valid, op_count, alu_a, alu_b, alu_sel, in_ready} !== 30'h0) begin n_fail++; $display("FAIL midop_reset got valid=%b cnt=%h a=%h b=%h sel=%h rdy=%b exp all 0", out_valid, op_count, alu_a, alu_b, alu_sel, in_ready); end
        reset = 1'b0;
        tick();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midop_ready got=%b exp=1", in_ready); end
        // Reset coinciding with the strobe cycle
        issue(8'h40, 8'h02, OP_ADD, ok);
        n_checks++; if (alu_do !== 1'b1) begin n_fail++; $display("FAIL exec_strobe got=%b exp=1", alu_do); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if (alu_do !== 1'b0) begin n_fail++; $display("FAIL exec_reset_do got=%b exp=0", alu_do); end
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin if (out_valid) vseen++; tick(); end
        out_ready = 1'b0;
        n_checks++; if (vseen != 0 || op_count !== 8'd0) begin n_fail++; $display("FAIL stale_result valid_cycles=%0d cnt=%0d exp 0/0", vseen, op_count); end
        issue(8'h02, 8'h03, OP_ADD, ok);
        wait_result(lat, dos, ok);
        n_checks++; if (!ok || out_y !== 8'h05 || lat != 3) begin n_fail++; $display("FAIL recover got y=%h lat=%0d exp y=05 lat=3", out_y, lat); end
        handshake();
    endtask

    task automatic test_latency4();
        int lat = 1, dos = 0, n = 0;
        in_a4 = 8'h7F; in_b4 = 8'h01; in_sel4 = OP_ADD; in_valid4 = 1'b1;
        while (!in_ready4 && n < 10) begin tick(); n++; end
        tick();
        in_valid4 = 1'b0;
        while (1) begin
            if (alu_do4) dos++;
            if (out_valid4 || lat >= 30) break;
            tick();
            lat++;
        end
        n_checks++; if (lat != 6 || dos != 1) begin n_fail++; $display("FAIL lat4_timing got lat=%0d dos=%0d exp lat=6 dos=1", lat, dos); end
        n_checks++; if ({out_y4, out_zero4, out_neg4, out_err4} !== {8'h80, 3'b010}) begin n_fail++; $display("FAIL lat4_result got=%h/%b%b%b exp=80/010", out_y4, out_zero4, out_neg4, out_err4); end
        out_ready4 = 1'b1;
        tick();
        out_ready4 = 1'b0;
        n_checks++; if (op_count4 !== 8'd1 || out_valid4 !== 1'b0) begin n_fail++; $display("FAIL lat4_count got=%0d valid=%b exp=1/0", op_count4, out_valid4); end
    endtask

    initial begin
        test_reset();
        test_sub_stall();
        test_flags();
        test_illegal();
        test_back_to_back();
        test_random_wrap();
        test_reset_mid_op();
        test_latency4();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog_timeout simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Upstream stage of the 8-bit ALU datapath (adder / two's-complement subtractor with registered Y).
- Accepts one operation (A, B, select) over a valid/ready handshake and holds the ALU operands stable.
- Issues the one-cycle `do` strobe, waits a fixed ALU latency, then captures Y plus status flags.
- Presents the result downstream over a second valid/ready handshake and counts completed operations.

Parameters:
- LATENCY, 1, cycles from the alu_do cycle to a valid alu_y; legal range 1..7.
- NUM_OPS, 8, number of legal select codes (0..NUM_OPS-1); codes at or above NUM_OPS are illegal.

Ports:
- clk  input  1  single system clock, all logic rising-edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream offers an operation.
- in_ready  output  1  block can accept; an operation is taken when in_valid&&in_ready at a rising edge.
- in_a  input  8  operand A.
- in_b  input  8  operand B.
- in_sel  input  4  ALU select code (OP_ADD=4'b0000, OP_SUB=4'b0001, others from the package).
- alu_a  output  8  operand A driven to the ALU.
- alu_b  output  8  operand B driven to the ALU.
- alu_sel  output  4  select driven to the ALU.
- alu_do  output  1  one-cycle execute strobe to the ALU.
- alu_y  input  8  ALU result.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_y  output  8  captured result.
- out_zero  output  1  out_y==0.
- out_neg  output  1  out_y[7].
- out_err  output  1  illegal select; out_y forced to 0.
- op_count  output  8  completed (handed-off) operations, wraps 0xFF->0x00.

Behaviour:
- States: IDLE, EXEC, WAIT, RESULT.
- Reset (synchronous) forces IDLE.
  - Registered outputs clear: alu_a/alu_b/alu_sel/out_y/op_count=0, out_zero/out_neg/out_err=0, out_valid=0, alu_do=0.
  - in_ready = (state==IDLE) && !reset, so it is 0 during reset and 1 the cycle after.
- IDLE: in_ready=1. On accept:
  - Latch in_a/in_b/in_sel into alu_a/alu_b/alu_sel.
  - Legal select: go to EXEC.
  - Illegal select (in_sel>=NUM_OPS): go straight to RESULT with out_y=0, out_err=1, out_zero=1, out_neg=0. alu_do is never pulsed, so out_valid rises 1 cycle after the accepting edge.
- EXEC: alu_do=1 for exactly this one cycle; load the wait counter with LATENCY-1; go to WAIT.
- WAIT:
  - While the counter is nonzero, decrement it.
  - When it is zero, capture out_y=alu_y, out_zero=(alu_y==0), out_neg=alu_y[7], out_err=0; go to RESULT.
  - Legal-op latency from the accepting edge to out_valid high: LATENCY+2 cycles.
- RESULT: out_valid=1; out_y and flags stay stable until handshake.
  - On out_valid&&out_ready: op_count+1 (mod 256), go to IDLE.
  - out_ready held high gives a single-cycle out_valid pulse.
  - Error results also increment op_count.
- alu_a/b/sel hold stable from accept until the next accept; changes on in_* outside IDLE are ignored.
- in_ready is 0 in EXEC, WAIT and RESULT, so there is no overlap: one op per LATENCY+3 cycles minimum.
- in_valid may drop without an accept; nothing happens.
- Reset asserted in any state aborts the operation at that edge:
  - No result is produced and op_count is cleared.
  - If reset coincides with the alu_do cycle, the strobe still appears that cycle, but its result is discarded.
- alu_do is never asserted in IDLE, WAIT or RESULT.

Decomposition:
- Shared package alu_pkg: select constants (OP_ADD, OP_SUB, and other op codes), NUM_OPS, the state enum (IDLE/EXEC/WAIT/RESULT), and the 8-bit data width constant, reused by the ALU and the bench.
- One natural sub-module, alu_flag_gen: combinational zero/negative flag derivation from an 8-bit value, reusable by the ALU.
- The FSM, wait counter and op counter stay in this module.

Test Plan:
- The bench ALU model registers Y one cycle after alu_do (LATENCY=1).
- SUB, stall: in_a=0x05, in_b=0x03, in_sel=OP_SUB, out_ready held low 4 cycles -> single alu_do pulse; out_valid at accept+3 and held; out_y=0x02, zero=0, neg=0, err=0; op_count 0->1 at the handshake.
- SUB to zero and negative: A=0x10, B=0x10 -> out_y=0x00, out_zero=1. Next op A=0x03, B=0x05 -> out_y=0xFE, out_neg=1.
- Illegal select: in_sel=4'hF -> no alu_do; out_valid 1 cycle after accept; out_y=0x00, out_err=1; op_count increments.
- Back-to-back: in_valid and out_ready held high for 10 ops of ADD A=i, B=1 -> in_ready low during each op; ten results 0x01..0x0A in order; op_count=10. Repeat with op_count preloaded near wrap by running 256 ops -> reads 0x00.
- Reset mid-op: assert reset in the WAIT cycle -> next cycle out_valid=0, op_count=0, alu_a/b/sel=0, in_ready=1 after reset deasserts; the stale alu_y is never presented.
- LATENCY=4 build: ADD 0x7F+0x01 -> out_valid at accept+6, out_y=0x80, out_neg=1.
